// File: rtl/inst_fetch_buffer.sv
// -----------------------------------------------------------------------------
// inst_fetch_buffer
//
// First-word-fall-through buffer that sits between the PC/fetch stage and
// decode. Each entry holds one fetched pair {pc, inst[63:0]}, where inst[31:0]
// is the instruction at pc and inst[63:32] is the one at pc+4. The head entry
// is presented to decode combinationally from storage, so a pair that is
// written at an edge is visible on id_* immediately after that edge.
//
// Ports
//   clk           single clock, all state on posedge
//   rst           asynchronous, active-low reset
//   ce_i          fetch chip-enable; low means no valid fetch this cycle
//   pc_i          8-byte aligned address of the fetched pair
//   inst_i        fetched pair ([31:0] at pc_i, [63:32] at pc_i+4)
//   inst_valid_i  memory return valid for pc_i/inst_i this cycle
//   flush_i       branch-taken flush; empties the buffer at the next edge
//   id_ready_i    decode accepts the head entry this cycle
//   id_valid_o    head entry valid (occupancy != 0)
//   id_pc_o       head entry pc (zero when empty)
//   id_inst0_o    head entry first instruction (zero when empty)
//   id_inst1_o    head entry second instruction (zero when empty)
//   stallreq_o    hold request to the PC stage (occupancy >= AFULL_LVL)
//   count_o       current occupancy
//   overflow_o    sticky: a fetch was dropped because the buffer was full
//
// Handshake: an entry moves to decode on a cycle where id_valid_o and
// id_ready_i are both high and flush_i is low; id_* do not depend on
// id_ready_i, and id_valid_o never drops without a pop, flush or reset.
// -----------------------------------------------------------------------------
module inst_fetch_buffer #(
  parameter int DEPTH     = 4,
  parameter int AFULL_LVL = DEPTH - 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ce_i,
  input  logic [31:0]              pc_i,
  input  logic [63:0]              inst_i,
  input  logic                     inst_valid_i,
  input  logic                     flush_i,
  input  logic                     id_ready_i,
  output logic                     id_valid_o,
  output logic [31:0]              id_pc_o,
  output logic [31:0]              id_inst0_o,
  output logic [31:0]              id_inst1_o,
  output logic                     stallreq_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     overflow_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_C  = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_C = CW'(AFULL_LVL);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;

  // Storage is deliberately left out of reset: occupancy alone decides
  // what is valid, and stale words are masked off the id_* outputs.
  logic [95:0]   mem_q [DEPTH];

  logic          empty, full;
  logic          fetch, push, pop, drop;
  logic [95:0]   head;

  always_comb begin
    empty = (count_q == '0);
    full  = (count_q == FULL_C);

    // A flush cancels both the fetch and the decode hand-off of this cycle.
    fetch = ce_i && inst_valid_i && !flush_i;
    pop   = !empty && id_ready_i && !flush_i;
    // At full, a same-cycle pop frees the slot the push lands in.
    push  = fetch && (!full || pop);
    drop  = fetch && full && !pop;

    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q | drop;

    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // Pointers wrap naturally because DEPTH is a power of two.
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (pop && !push) count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {pc_i, inst_i};
  end

  always_comb begin
    head       = mem_q[rd_ptr_q];
    id_valid_o = !empty;
    id_pc_o    = empty ? 32'h0 : head[95:64];
    id_inst0_o = empty ? 32'h0 : head[31:0];
    id_inst1_o = empty ? 32'h0 : head[63:32];
    // Asserting one entry early leaves room for the fetch already in flight.
    stallreq_o = (count_q >= AFULL_C);
    count_o    = count_q;
    overflow_o = overflow_q;
  end

endmodule

// File: tb/tb_inst_fetch_buffer.sv
module tb_inst_fetch_buffer;

  localparam int DEPTH = 4;
  localparam int AFULL = DEPTH - 1;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ce_i = 1'b0;
  logic [31:0] pc_i = '0;
  logic [63:0] inst_i = '0;
  logic        inst_valid_i = 1'b0;
  logic        flush_i = 1'b0;
  logic        id_ready_i = 1'b0;
  logic        id_valid_o;
  logic [31:0] id_pc_o;
  logic [31:0] id_inst0_o;
  logic [31:0] id_inst1_o;
  logic        stallreq_o;
  logic [2:0]  count_o;
  logic        overflow_o;

  always #5 clk = ~clk;

  inst_fetch_buffer #(.DEPTH(DEPTH), .AFULL_LVL(AFULL)) dut (
    .clk          (clk),
    .rst          (rst),
    .ce_i         (ce_i),
    .pc_i         (pc_i),
    .inst_i       (inst_i),
    .inst_valid_i (inst_valid_i),
    .flush_i      (flush_i),
    .id_ready_i   (id_ready_i),
    .id_valid_o   (id_valid_o),
    .id_pc_o      (id_pc_o),
    .id_inst0_o   (id_inst0_o),
    .id_inst1_o   (id_inst1_o),
    .stallreq_o   (stallreq_o),
    .count_o      (count_o),
    .overflow_o   (overflow_o)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  int total = 0;
  int bad   = 0;
  bit mon_en = 1'b0;
  logic [95:0] exp_q[$];   // expected buffer contents, oldest first: {pc, inst}
  logic        model_ovf = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue with the buffer's acceptance rules.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      exp_q.delete();
      model_ovf <= 1'b0;
    end else begin
      int  m_size;
      bit  m_pop, m_fetch;
      m_size  = exp_q.size();
      m_pop   = (m_size != 0) && id_ready_i && !flush_i;
      m_fetch = ce_i && inst_valid_i && !flush_i;
      if (flush_i) begin
        exp_q.delete();
      end else begin
        if (m_pop) void'(exp_q.pop_front());
        if (m_fetch) begin
          if (m_size < DEPTH || m_pop) exp_q.push_back({pc_i, inst_i});
          else model_ovf <= 1'b1;
        end
      end
    end
  end

  // Monitor: compares the DUT's presented state to the model every cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      int n;
      logic [95:0] hd;
      n = exp_q.size();
      check("count", 64'(count_o), 64'(n));
      check("valid", 64'(id_valid_o), 64'(n != 0));
      check("stall", 64'(stallreq_o), 64'(n >= AFULL));
      check("overflow", 64'(overflow_o), 64'(model_ovf));
      if (n != 0) begin
        hd = exp_q[0];
        check("head_pc", 64'(id_pc_o), 64'(hd[95:64]));
        check("head_inst0", 64'(id_inst0_o), 64'(hd[31:0]));
        check("head_inst1", 64'(id_inst1_o), 64'(hd[63:32]));
      end else begin
        check("empty_pc", 64'(id_pc_o), 64'h0);
        check("empty_inst", {id_inst1_o, id_inst0_o}, 64'h0);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks (inputs change 1 time unit after the rising edge)
  // ---------------------------------------------------------------------------
  task automatic step(input bit ce, input bit vld, input logic [31:0] pc,
                      input logic [63:0] inst, input bit fl, input bit rdy);
    ce_i = ce; inst_valid_i = vld; pc_i = pc; inst_i = inst;
    flush_i = fl; id_ready_i = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] pc, input bit rdy);
    step(1'b1, 1'b1, pc, {~pc, pc ^ 32'h5a5a_0000}, 1'b0, rdy);
  endtask

  task automatic idle(input bit rdy);
    step(1'b0, 1'b0, 32'h0, 64'h0, 1'b0, rdy);
  endtask

  task automatic do_reset();
    ce_i = 0; inst_valid_i = 0; flush_i = 0; id_ready_i = 0;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    mon_en = 1'b1;
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    do_reset();
    check("rst_count", 64'(count_o), 64'h0);
    check("rst_valid", 64'(id_valid_o), 64'h0);

    // First push is visible right after the edge.
    step(1'b1, 1'b1, 32'h0, 64'h11112222_33334444, 1'b0, 1'b0);
    check("ffwt_valid", 64'(id_valid_o), 64'h1);
    check("ffwt_pc", 64'(id_pc_o), 64'h0);
    check("ffwt_inst0", 64'(id_inst0_o), 64'h33334444);
    check("ffwt_inst1", 64'(id_inst1_o), 64'h11112222);

    // Fill up, then overflow.
    push(32'h8, 1'b0);
    push(32'h10, 1'b0);
    check("fill3_count", 64'(count_o), 64'h3);
    check("fill3_stall", 64'(stallreq_o), 64'h1);
    push(32'h18, 1'b0);
    check("fill4_count", 64'(count_o), 64'h4);
    push(32'h20, 1'b0);
    check("drop_count", 64'(count_o), 64'h4);
    check("drop_ovf", 64'(overflow_o), 64'h1);

    // Push and pop at full.
    push(32'h20, 1'b1);
    check("fullpp_count", 64'(count_o), 64'h4);
    check("fullpp_head", 64'(id_pc_o), 64'h8);
    idle(1'b1);
    idle(1'b1);
    idle(1'b1);
    check("tail_pc", 64'(id_pc_o), 64'h20);
    check("tail_count", 64'(count_o), 64'h1);

    // Flush at count 3 with push and ready in the same cycle.
    push(32'h28, 1'b0);
    push(32'h30, 1'b0);
    check("preflush_count", 64'(count_o), 64'h3);
    step(1'b1, 1'b1, 32'h38, 64'hdead_beef_0bad_f00d, 1'b1, 1'b1);
    check("flush_count", 64'(count_o), 64'h0);
    check("flush_valid", 64'(id_valid_o), 64'h0);
    check("flush_ovf", 64'(overflow_o), 64'h1);

    // Streaming with decode always ready: pointers wrap several times.
    @(posedge clk); #1;
    do_reset();
    check("rst_ovf", 64'(overflow_o), 64'h0);
    for (int i = 0; i < 10; i++) begin
      push(32'(i * 8), 1'b1);
      check("stream_pc", 64'(id_pc_o), 64'(i * 8));
      check("stream_count", 64'(count_o), 64'h1);
    end
    idle(1'b1);
    check("stream_empty", 64'(count_o), 64'h0);
    check("stream_ovf", 64'(overflow_o), 64'h0);

    // ce_i low masks inst_valid_i.
    step(1'b0, 1'b1, 32'h40, 64'h1, 1'b0, 1'b0);
    check("ce_low_count", 64'(count_o), 64'h0);

    // Asynchronous reset mid-stream at count 2.
    push(32'h100, 1'b0);
    push(32'h108, 1'b0);
    check("pre_arst_count", 64'(count_o), 64'h2);
    #2;
    rst = 1'b0;
    #1;
    check("arst_count", 64'(count_o), 64'h0);
    check("arst_valid", 64'(id_valid_o), 64'h0);
    check("arst_pc", 64'(id_pc_o), 64'h0);
    check("arst_stall", 64'(stallreq_o), 64'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    // Push on the first edge after release.
    push(32'h200, 1'b0);
    check("post_rst_valid", 64'(id_valid_o), 64'h1);
    check("post_rst_pc", 64'(id_pc_o), 64'h200);

    // Randomized traffic checked by the monitor against the model.
    for (int i = 0; i < 600; i++) begin
      step(1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 3) != 0),
           {$urandom_range(0, 32'h1fff_ffff), 3'b000}[31:0],
           {$urandom, $urandom},
           1'($urandom_range(0, 19) == 0),
           1'($urandom_range(0, 1)));
      if (i == 300) begin
        #2;
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
      end
    end
    idle(1'b1);
    repeat (DEPTH + 1) idle(1'b1);
    check("final_empty", 64'(count_o), 64'h0);

    @(negedge clk);
    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/inst_fetch_buffer.md
INST_FETCH_BUFFER -- requirements
Module: inst_fetch_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of fetch-pair entries (power of two, >= 2).
REQ-002 SHALL have parameter AFULL_LVL, default DEPTH-1, occupancy at which stallreq_o asserts.
REQ-003 SHALL have port clk, input, 1, single clock; all state on posedge clk.
REQ-004 SHALL have port rst, input, 1, reset; asynchronous and active-low; one clock.
REQ-005 SHALL have port ce_i, input, 1, fetch chip-enable from PC stage; low means no valid fetch.
REQ-006 SHALL have port pc_i, input, 32, address of fetched pair; always 8-byte aligned.
REQ-007 SHALL have port inst_i, input, 64, fetched pair: [31:0] at pc_i, [63:32] at pc_i+4.
REQ-008 SHALL have port inst_valid_i, input, 1, memory return valid for pc_i/inst_i this cycle.
REQ-009 SHALL have port flush_i, input, 1, branch-taken flush from execute.
REQ-010 SHALL have port id_ready_i, input, 1, decode accepts the head entry this cycle.
REQ-011 SHALL have port id_valid_o, output, 1, head entry valid.
REQ-012 SHALL have port id_pc_o, output, 32, head entry pc.
REQ-013 SHALL have port id_inst0_o, output, 32, head entry first instruction.
REQ-014 SHALL have port id_inst1_o, output, 32, head entry second instruction.
REQ-015 SHALL have port stallreq_o, output, 1, request to hold PC stage (feeds stall[0]).
REQ-016 SHALL have port count_o, output, log2(DEPTH)+1, current occupancy.
REQ-017 SHALL have port overflow_o, output, 1, sticky error: fetch dropped while full.

Function
REQ-018 SHALL be a first-word-fall-through FIFO; head entry drives id_* combinationally from storage, zero latency after write.
REQ-019 SHALL push {pc_i, inst_i} when ce_i && inst_valid_i && !flush_i and (count < DEPTH or pop this cycle).
REQ-020 SHALL pop when id_valid_o && id_ready_i && !flush_i.
REQ-021 SHALL leave count unchanged on simultaneous push and pop, including at full and at count 1.
REQ-022 SHALL wrap read/write pointers modulo DEPTH; count never exceeds DEPTH nor underflows.
REQ-023 SHALL assert id_valid_o iff count != 0.
REQ-024 SHALL drive id_pc_o, id_inst0_o, id_inst1_o to zero when count == 0.
REQ-025 SHALL, on flush_i, set count and both pointers to 0 at the next edge, discarding any same-cycle push and pop.
REQ-026 SHALL drive stallreq_o = (count >= AFULL_LVL), combinational from registered count, covering the one in-flight fetch.
REQ-027 SHALL drop a push arriving at full without same-cycle pop and set overflow_o at the next edge.
REQ-028 SHALL hold overflow_o set until reset; flush_i does not clear it.
REQ-029 SHALL ignore inst_valid_i when ce_i is low.
REQ-030 SHALL preserve entry order; entries popped in push order with pc/inst pairing intact.

Reset
REQ-031 SHALL, while rst is low, asynchronously clear count, pointers and overflow_o; id_valid_o=0, stallreq_o=0, count_o=0, id_* data=0.
REQ-032 SHALL discard all entries on reset asserted mid-operation; storage contents need not be cleared.
REQ-033 SHALL accept a push on the first posedge after rst deasserts.

Verification
REQ-034 SHALL cover: reset, push pc=0x0 inst=0x11112222_33334444 -> same cycle after edge id_valid_o=1, id_pc_o=0, id_inst0_o=0x33334444, id_inst1_o=0x11112222.
REQ-035 SHALL cover: id_ready_i=0, pushes at pc 0x0,0x8,0x10 -> count_o=3, stallreq_o=1; fourth push -> count_o=4; fifth push -> dropped, overflow_o=1, count_o=4.
REQ-036 SHALL cover: full, push and pop same cycle -> count_o stays 4, head advances to pc 0x8, new tail pc 0x20.
REQ-037 SHALL cover: count 3, flush_i with push and ready same cycle -> next cycle count_o=0, id_valid_o=0, overflow_o unchanged.
REQ-038 SHALL cover: 10 pushes with continuous id_ready_i=1 -> pointers wrap, pcs 0x0..0x48 popped in order, no overflow.
REQ-039 SHALL cover: rst low mid-stream at count 2 -> immediately count_o=0, id_valid_o=0, without a clock edge.
